simon_control: RTL and testbench

FSM that sequences the Simon game by driving the datapath's counter, memory and display controls. It consumes the datapath status flags (`index_lt_count`, `pattern_eq_mem`, `pattern_valid`) and produces every datapath control strobe plus the 3-bit mode LEDs. It sits directly upstream of the datapath: one `clk` edge is one player button press. Only the state is registered; all outputs are decoded from state, status inputs and `reset`.

---
 rtl/simon_pkg.sv | 18 +
 rtl/simon_control.sv | 123 ++++++++++++
 tb/tb_simon_control.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared Simon game definitions: controller state encoding and mode LED patterns.
// No logic; imported by the controller and by the datapath bench.
// Four states fill the 2-bit encoding.
package simon_pkg;

    typedef enum logic [1:0] {
        ST_INPUT    = 2'd0,
        ST_PLAYBACK = 2'd1,
        ST_REPEAT   = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [2:0] LED_MODE_INPUT    = 3'b001;
    localparam logic [2:0] LED_MODE_PLAYBACK = 3'b010;
    localparam logic [2:0] LED_MODE_REPEAT   = 3'b100;
    localparam logic [2:0] LED_MODE_DONE     = 3'b111;

endpackage

// File: rtl/simon_control.sv
// Simon game sequencer: drives datapath counter/memory/display strobes from status flags.
// Outputs are combinational from state, status and reset; one transition per clk edge.
// No backpressure; optional SIMON_CTRL_FULL_GUARD_EN adds count_full to stop count at 63.
module simon_control
    import simon_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       index_lt_count,
    input  logic       pattern_eq_mem,
    input  logic       pattern_valid,
`ifdef SIMON_CTRL_FULL_GUARD_EN
    input  logic       count_full,
`endif
    output logic       count_cnt,
    output logic       count_clr,
    output logic       index_cnt,
    output logic       index_clr,
    output logic       write_en,
    output logic       load_level,
    output logic       disp_mem,
    output logic [2:0] mode_leds
);

    state_t state_q;
    state_t state_d;
    logic   last_full;

`ifdef SIMON_CTRL_FULL_GUARD_EN
    // A full sequence must not advance count, or it would wrap back to zero.
    assign last_full = count_full;
`else
    // Without the guard, count simply wraps modulo 64.
    assign last_full = 1'b0;
`endif

    // State register with synchronous reset back to INPUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INPUT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; reset overrides every state's decode.
    always_comb begin
        state_d    = state_q;
        count_cnt  = 1'b0;
        count_clr  = 1'b0;
        index_cnt  = 1'b0;
        index_clr  = 1'b0;
        write_en   = 1'b0;
        load_level = 1'b0;
        disp_mem   = 1'b0;
        mode_leds  = LED_MODE_DONE;

        case (state_q)
            ST_INPUT: begin
                mode_leds = LED_MODE_INPUT;
                if (pattern_valid) begin
                    write_en  = 1'b1;
                    index_clr = 1'b1;
                    state_d   = ST_PLAYBACK;
                end
            end
            ST_PLAYBACK: begin
                mode_leds = LED_MODE_PLAYBACK;
                disp_mem  = 1'b1;
                if (index_lt_count) begin
                    index_cnt = 1'b1;
                end else begin
                    index_clr = 1'b1;
                    state_d   = ST_REPEAT;
                end
            end
            ST_REPEAT: begin
                mode_leds = LED_MODE_REPEAT;
                // A mismatch ends the game regardless of position.
                if (!pattern_eq_mem) begin
                    index_clr = 1'b1;
                    state_d   = ST_DONE;
                end else if (index_lt_count) begin
                    index_cnt = 1'b1;
                end else if (last_full) begin
                    index_clr = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    count_cnt = 1'b1;
                    state_d   = ST_INPUT;
                end
            end
            ST_DONE: begin
                mode_leds = LED_MODE_DONE;
                disp_mem  = 1'b1;
                if (index_lt_count) begin
                    index_cnt = 1'b1;
                end else begin
                    index_clr = 1'b1;
                end
            end
            default: begin
                // Illegal encodings show DONE and recover through INPUT.
                mode_leds = LED_MODE_DONE;
                disp_mem  = 1'b1;
                state_d   = ST_INPUT;
            end
        endcase

        if (reset) begin
            count_cnt  = 1'b0;
            index_cnt  = 1'b0;
            write_en   = 1'b0;
            disp_mem   = 1'b0;
            load_level = 1'b1;
            count_clr  = 1'b1;
            index_clr  = 1'b1;
            mode_leds  = LED_MODE_INPUT;
            state_d    = ST_INPUT;
        end
    end

endmodule

// File: tb/tb_simon_control.sv
// Bench for simon_control: directed game steps, then a randomised game against a
// game-level model that also plays the datapath (count, index) from expected strobes.
module tb_simon_control;

`ifdef SIMON_CTRL_FULL_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       index_lt_count;
    logic       pattern_eq_mem;
    logic       pattern_valid;
    logic       count_full;
    logic       count_cnt;
    logic       count_clr;
    logic       index_cnt;
    logic       index_clr;
    logic       write_en;
    logic       load_level;
    logic       disp_mem;
    logic [2:0] mode_leds;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: the game phase as the LED code the player sees.
    logic [2:0] cur_mode;
    logic [9:0] last_exp;

    // Datapath model used in the random phase.
    int dp_count;
    int dp_index;

    simon_control dut (
        .clk            (clk),
        .reset          (reset),
        .index_lt_count (index_lt_count),
        .pattern_eq_mem (pattern_eq_mem),
        .pattern_valid  (pattern_valid),
`ifdef SIMON_CTRL_FULL_GUARD_EN
        .count_full     (count_full),
`endif
        .count_cnt      (count_cnt),
        .count_clr      (count_clr),
        .index_cnt      (index_cnt),
        .index_clr      (index_clr),
        .write_en       (write_en),
        .load_level     (load_level),
        .disp_mem       (disp_mem),
        .mode_leds      (mode_leds)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Game rules: returns {next_mode, cc, cclr, ic, iclr, we, ll, dm, leds}.
    function automatic logic [12:0] rules(input logic [2:0] mode, input logic rst,
                                          input logic valid, input logic lt,
                                          input logic eq, input logic full);
        logic cc, cclr, ic, iclr, we, ll, dm;
        logic [2:0] leds, nxt;
        cc = 0; cclr = 0; ic = 0; iclr = 0; we = 0; ll = 0; dm = 0;
        leds = mode; nxt = mode;
        if (rst) begin
            ll = 1; cclr = 1; iclr = 1; leds = 3'b001; nxt = 3'b001;
        end else if (mode == 3'b001) begin
            if (valid) begin we = 1; iclr = 1; nxt = 3'b010; end
        end else if (mode == 3'b010) begin
            dm = 1;
            if (lt) ic = 1; else begin iclr = 1; nxt = 3'b100; end
        end else if (mode == 3'b100) begin
            if (!eq) begin iclr = 1; nxt = 3'b111; end
            else if (lt) ic = 1;
            else if (GUARD && full) begin iclr = 1; nxt = 3'b111; end
            else begin cc = 1; nxt = 3'b001; end
        end else begin
            dm = 1;
            if (lt) ic = 1; else iclr = 1;
        end
        return {nxt, cc, cclr, ic, iclr, we, ll, dm, leds};
    endfunction

    // One button press: drive status, check decoded outputs mid-cycle, clock, check mode.
    task automatic cycle(input logic rst, input logic valid, input logic lt,
                         input logic eq, input logic full);
        logic [12:0] r;
        logic [9:0]  obs;
        reset = rst; pattern_valid = valid; index_lt_count = lt;
        pattern_eq_mem = eq; count_full = full;
        #4;
        r = rules(cur_mode, rst, valid, lt, eq, full);
        obs = {count_cnt, count_clr, index_cnt, index_clr, write_en,
               load_level, disp_mem, mode_leds};
        last_exp = r[9:0];
        n_assert++;
        assert (obs === r[9:0]) else begin
            n_fail++;
            $error("FAIL outputs mode=%b obs=%b exp=%b (cc cclr ic iclr we ll dm leds)",
                   cur_mode, obs, r[9:0]);
        end
        n_assert++;
        assert (((count_cnt & count_clr) | (index_cnt & index_clr)) === 1'b0) else begin
            n_fail++;
            $error("FAIL strobe_pair obs cc/cclr=%b%b ic/iclr=%b%b exp no pair high",
                   count_cnt, count_clr, index_cnt, index_clr);
        end
        @(posedge clk);
        #1;
        cur_mode = r[12:10];
        n_assert++;
        assert (mode_leds === cur_mode) else begin
            n_fail++;
            $error("FAIL next_mode obs=%b exp=%b", mode_leds, cur_mode);
        end
    endtask

    initial begin
        reset = 1'b1; pattern_valid = 1'b0; index_lt_count = 1'b0;
        pattern_eq_mem = 1'b0; count_full = 1'b0;
        cur_mode = 3'b001; last_exp = '0;
        dp_count = 0; dp_index = 0;
        @(posedge clk);
        #1;

        // Reset with a valid pattern present: nothing is written.
        cycle(1, 1, 0, 0, 0);
        // INPUT holds on invalid patterns, then takes a valid one.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        // PLAYBACK steps twice then moves to REPEAT.
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        // REPEAT final match: next round.
        cycle(0, 0, 0, 1, 0);
        // Another round ending in a mismatch; DONE loops for 10 edges.
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, $urandom_range(0, 1), i % 3 != 2, $urandom_range(0, 1), 0);
        // Reset mid-REPEAT: count cleared, never incremented.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(1, 0, 0, 1, 0);
        // Final-entry match with a full count.
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 1);
        cycle(1, 0, 0, 0, 0);

        // Random game: status derived from a modelled datapath.
        dp_count = 0; dp_index = 0;
        for (int n = 0; n < 2000; n++) begin
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                  dp_index < dp_count, $urandom_range(0, 15) != 0, dp_count == 63);
            if (last_exp[8]) dp_count = 0;
            else if (last_exp[9]) dp_count = (dp_count + 1) % 64;
            if (last_exp[6]) dp_index = 0;
            else if (last_exp[7]) dp_index = dp_index + 1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
